// File: rtl/rx_pkg.sv
// Shared Rx definitions: parity mode encodings, engine FSM states, default width.
// Also used by the Tx parity generator.
package rx_pkg;

    localparam int RX_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } par_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_DONE
    } rx_state_e;

    // Encodings 5..7 fall back to "no parity bit".
    function automatic logic has_parity(input logic [2:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
               (mode == PAR_MARK) || (mode == PAR_SPACE);
    endfunction

endpackage

// File: rtl/rx_parity_calc.sv
// Expected parity bit for a given mode and running XOR of the data bits.
// Purely combinational; shared with the Tx parity generator.
module rx_parity_calc
    import rx_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       run_par,
    output logic       exp_par
);

    always_comb begin
        exp_par = 1'b0;
        case (mode)
            PAR_EVEN:  exp_par = run_par;
            PAR_ODD:   exp_par = ~run_par;
            PAR_MARK:  exp_par = 1'b1;
            PAR_SPACE: exp_par = 1'b0;
            default:   exp_par = 1'b0;
        endcase
    end

endmodule

// File: rtl/rx_parity_check_engine.sv
// Rx frame tracker: LSB-first data shift, run-time parity check, valid strobe.
// Define RX_PARITY_ERR_CNT_EN to enable the saturating parity-error counter.
module rx_parity_check_engine
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            parity_mode,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  serial_in_synced,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  rx_error,
    output logic [CNT_WIDTH-1:0]  parity_err_count
);

    rx_state_e             state_q, state_d;
    logic [2:0]            mode_q, mode_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  err_q, err_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  rxerr_q, rxerr_d;
    logic                  exp_par;

    rx_parity_calc u_calc (
        .mode    (mode_q),
        .run_par (par_q),
        .exp_par (exp_par)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        err_d   = err_q;
        pend_d  = pend_q;
        data_d  = data_q;
        valid_d = 1'b0;
        rxerr_d = rxerr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start || pend_q) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                    if (frame_start) mode_d = parity_mode;
                end
            end
            ST_DATA, ST_PARITY: begin
                if (frame_start) begin
                    // Abort: restart cleanly with a freshly latched mode.
                    state_d = ST_DATA;
                    mode_d  = parity_mode;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    err_d   = 1'b0;
                end else if (bit_valid && state_q == ST_DATA) begin
                    shift_d = {serial_in_synced, shift_q[DATA_WIDTH-1:1]};
                    par_d   = par_q ^ serial_in_synced;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'(DATA_WIDTH - 1))
                        state_d = has_parity(mode_q) ? ST_PARITY : ST_DONE;
                end else if (bit_valid) begin
                    err_d   = (serial_in_synced != exp_par);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                data_d  = shift_q;
                valid_d = 1'b1;
                rxerr_d = err_q;
                state_d = ST_IDLE;
                if (frame_start) begin
                    pend_d = 1'b1;
                    mode_d = parity_mode;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            rxerr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            rxerr_q <= rxerr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign rx_error   = rxerr_q;

`ifdef RX_PARITY_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] errcnt_q, errcnt_d;

    // Counts in step with the data_valid strobe it belongs to.
    always_comb begin
        errcnt_d = errcnt_q;
        if (state_q == ST_DONE && err_q && errcnt_q != '1)
            errcnt_d = errcnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) errcnt_q <= '0;
        else       errcnt_q <= errcnt_d;
    end

    assign parity_err_count = errcnt_q;
`else
    assign parity_err_count = '0;
`endif

endmodule

// File: tb/tb_rx_parity_check_engine.sv
// Scoreboard bench for rx_parity_check_engine: directed plan cases plus
// randomized frames checked against a parity-rule reference model.
module tb_rx_parity_check_engine;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    parity_mode;
    logic          frame_start;
    logic          bit_valid;
    logic          serial_in_synced;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          rx_error;
    logic [CW-1:0] parity_err_count;

    int vectors = 0;
    int miscompares = 0;
    int errs = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            c;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    rx_parity_check_engine #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .parity_mode      (parity_mode),
        .frame_start      (frame_start),
        .bit_valid        (bit_valid),
        .serial_in_synced (serial_in_synced),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .rx_error         (rx_error),
        .parity_err_count (parity_err_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mode_has_par(input logic [2:0] m);
        return (m >= 3'd1) && (m <= 3'd4);
    endfunction

    // Reference: the parity bit must make the frame obey the mode's rule.
    function automatic bit model_err(input logic [2:0] m, input logic [DW-1:0] d,
                                     input logic p);
        bit odd_ones;
        odd_ones = ($countones(d) % 2) == 1;
        case (m)
            3'd1:    return p != odd_ones;
            3'd2:    return p == odd_ones;
            3'd3:    return p != 1'b1;
            3'd4:    return p != 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_cnt();
`ifdef RX_PARITY_ERR_CNT_EN
        return (errs > 3) ? 3 : errs;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && data_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("data_out", int'(data_out), int'(e.d));
                chk("rx_error", int'(rx_error), int'(e.e));
                chk("err_count", int'(parity_err_count), e.c);
            end
        end
    end

    task automatic pulse_bit(input logic b);
        bit_valid = 1'b1;
        serial_in_synced = b;
        @(negedge clk);
        bit_valid = 1'b0;
        serial_in_synced = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic start_pulse(input logic [2:0] m);
        parity_mode = m;
        frame_start = 1'b1;
        bit_valid = 1'($urandom);
        serial_in_synced = 1'($urandom);
        @(negedge clk);
        frame_start = 1'b0;
        bit_valid = 1'b0;
        parity_mode = 3'($urandom);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [2:0] m, input logic [DW-1:0] d,
                              input logic p, input bit do_start,
                              input bit chain, input logic [2:0] nm);
        int   nbits;
        logic b;
        exp_t e;
        if (do_start) start_pulse(m);
        nbits = mode_has_par(m) ? DW + 1 : DW;
        for (int i = 0; i < nbits; i++) begin
            b = (i < DW) ? d[i] : p;
            if (i == nbits - 1) begin
                e.e = model_err(m, d, p);
                if (e.e) errs++;
                e.d = d;
                e.c = model_cnt();
                q.push_back(e);
                bit_valid = 1'b1;
                serial_in_synced = b;
                @(negedge clk);
                bit_valid = 1'b0;
                chk("latency_early", int'(data_valid), 0);
                if (chain) begin
                    frame_start = 1'b1;
                    parity_mode = nm;
                end
                @(negedge clk);
                frame_start = 1'b0;
                chk("latency_2cyc", int'(data_valid), 1);
                @(negedge clk);
                chk("valid_1cyc", int'(data_valid), 0);
                repeat (2) @(negedge clk);
            end else begin
                pulse_bit(b);
            end
        end
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit          chained;
        logic [2:0]  m, nm;
        logic [DW-1:0] d;
        logic        p;

        reset = 1'b1;
        parity_mode = '0;
        frame_start = 1'b0;
        bit_valid = 1'b0;
        serial_in_synced = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_error", int'(rx_error), 0);
        chk("rst_count", int'(parity_err_count), 0);
        reset = 1'b0;
        @(negedge clk);

        send_frame(3'd1, 8'hA5, 1'b0, 1, 0, 3'd0);
        send_frame(3'd2, 8'h01, 1'b0, 1, 0, 3'd0);
        send_frame(3'd2, 8'h01, 1'b1, 1, 0, 3'd0);
        send_frame(3'd3, 8'h3C, 1'b0, 1, 0, 3'd0);
        send_frame(3'd4, 8'h3C, 1'b0, 1, 0, 3'd0);
        send_frame(3'd0, 8'hFF, 1'b1, 1, 0, 3'd0);
        pulse_bit(1'b1);
        pulse_bit(1'b0);

        start_pulse(3'd1);
        for (int i = 0; i < 4; i++) pulse_bit(1'($urandom));
        send_frame(3'd1, 8'h5A, 1'b0, 1, 0, 3'd0);

        send_frame(3'd2, 8'h01, 1'b1, 1, 0, 3'd0);
        start_pulse(3'd2);
        for (int i = 0; i < 3; i++) pulse_bit(1'b1);
        reset = 1'b1;
        errs = 0;
        @(negedge clk);
        chk("midrst_data_out", int'(data_out), 0);
        chk("midrst_valid", int'(data_valid), 0);
        chk("midrst_error", int'(rx_error), 0);
        chk("midrst_count", int'(parity_err_count), 0);
        reset = 1'b0;
        @(negedge clk);
        send_frame(3'd1, 8'h5A, 1'b0, 1, 0, 3'd0);

        for (int i = 0; i < 5; i++)
            send_frame(3'd2, 8'h01, 1'b1, 1, 0, 3'd0);

        send_frame(3'd1, 8'h12, 1'b1, 1, 1, 3'd2);
        send_frame(3'd2, 8'h34, 1'b1, 0, 0, 3'd0);

        chained = 1'b0;
        m = 3'($urandom_range(0, 7));
        for (int i = 0; i < 60; i++) begin
            d  = DW'($urandom);
            p  = 1'($urandom);
            nm = 3'($urandom_range(0, 7));
            send_frame(m, d, p, !chained, (i % 4) == 3, nm);
            chained = (i % 4) == 3;
            m = chained ? nm : 3'($urandom_range(0, 7));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
